// File: rtl/permutation_state_register_pkg.sv
// Shared types and defaults for the permutation state register and its round sequencer.
package permutation_state_register_pkg;

  localparam int unsigned DefaultMaxRounds = 12;
  localparam int unsigned DefaultRoundW    = 4;

  // Five 64-bit words x0..x4; index 0 is x0.
  typedef logic [4:0][63:0] t_state_array;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } t_perm_fsm;

endpackage

// File: rtl/permutation_state_register_if.sv
// Handshake and data bundle between the top-level controller, round datapath and state register.
interface permutation_state_register_if
  import permutation_state_register_pkg::*;
#(
  parameter int unsigned ROUND_W = DefaultRoundW
) ();

  logic               i_load;
  t_state_array       i_state_init;
  logic               i_start;
  logic [ROUND_W-1:0] i_num_rounds;
  t_state_array       i_state_round;
  logic               i_ready;
  t_state_array       o_state;
  logic [ROUND_W-1:0] o_round;
  logic               o_busy;
  logic               o_valid;

  modport master (
    output i_load, i_state_init, i_start, i_num_rounds, i_state_round, i_ready,
    input  o_state, o_round, o_busy, o_valid
  );

  modport slave (
    input  i_load, i_state_init, i_start, i_num_rounds, i_state_round, i_ready,
    output o_state, o_round, o_busy, o_valid
  );

endinterface

// File: rtl/permutation_state_register_round_counter.sv
// Round index up-counter plus remaining-rounds down-counter; flags the final round.
module permutation_state_register_round_counter
  import permutation_state_register_pkg::*;
#(
  parameter int unsigned MAX_ROUNDS = DefaultMaxRounds,
  parameter int unsigned ROUND_W    = DefaultRoundW
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start_i,
  input  logic [ROUND_W-1:0] num_rounds_i,
  input  logic               advance_i,
  output logic [ROUND_W-1:0] round_o,
  output logic               last_round_o
);

  localparam logic [ROUND_W-1:0] MaxRoundsW = ROUND_W'(MAX_ROUNDS);

  logic [ROUND_W-1:0] round_q, round_d;
  logic [ROUND_W-1:0] remaining_q, remaining_d;

  assign last_round_o = (remaining_q == ROUND_W'(1));
  assign round_o      = round_q;

  always_comb begin
    round_d     = round_q;
    remaining_d = remaining_q;
    if (start_i) begin
      // Short permutations start late so the last round always uses index MAX_ROUNDS-1.
      round_d     = MaxRoundsW - num_rounds_i;
      remaining_d = num_rounds_i;
    end else if (advance_i) begin
      remaining_d = remaining_q - ROUND_W'(1);
      if (!last_round_o) begin
        round_d = round_q + ROUND_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      round_q     <= '0;
      remaining_q <= '0;
    end else begin
      round_q     <= round_d;
      remaining_q <= remaining_d;
    end
  end

endmodule

// File: rtl/permutation_state_register.sv
// 320-bit permutation state register with IDLE/RUN/DONE sequencer closing the round loop.
module permutation_state_register
  import permutation_state_register_pkg::*;
#(
  parameter int unsigned MAX_ROUNDS = DefaultMaxRounds,
  parameter int unsigned ROUND_W    = DefaultRoundW
) (
  input logic                         clock,
  input logic                         reset_n,
  permutation_state_register_if.slave bus
);

  localparam logic [ROUND_W-1:0] MaxRoundsW = ROUND_W'(MAX_ROUNDS);

  t_perm_fsm    fsm_q, fsm_d;
  t_state_array state_q, state_d;
  logic         start_ok;
  logic         advance;
  logic         last_round;
  logic         count_legal;

  assign count_legal = (bus.i_num_rounds != '0) && (bus.i_num_rounds <= MaxRoundsW);

  always_comb begin
    fsm_d    = fsm_q;
    start_ok = 1'b0;
    advance  = 1'b0;
    unique case (fsm_q)
      StIdle: begin
        if (bus.i_start && count_legal) begin
          start_ok = 1'b1;
          fsm_d    = StRun;
        end
      end
      StRun: begin
        advance = 1'b1;
        if (last_round) begin
          fsm_d = StDone;
        end
      end
      StDone: begin
        if (bus.i_ready) begin
          fsm_d = StIdle;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (fsm_q == StIdle && bus.i_load) begin
      state_d = bus.i_state_init;
    end else if (fsm_q == StRun) begin
      state_d = bus.i_state_round;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q   <= StIdle;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
    end
  end

  permutation_state_register_round_counter #(
    .MAX_ROUNDS (MAX_ROUNDS),
    .ROUND_W    (ROUND_W)
  ) u_round_counter (
    .clock        (clock),
    .reset_n      (reset_n),
    .start_i      (start_ok),
    .num_rounds_i (bus.i_num_rounds),
    .advance_i    (advance),
    .round_o      (bus.o_round),
    .last_round_o (last_round)
  );

  assign bus.o_state = state_q;
  assign bus.o_busy  = (fsm_q == StRun);
  assign bus.o_valid = (fsm_q == StDone);

endmodule
